su_cmd_engine: RTL and testbench
================================

// Module: su_cmd_engine
// PURPOSE
//  Synthesizable smart-UART command engine. Sits between a UART byte receiver/transmitter pair and the on-chip memory bus.
//  Decodes SU_CMD_WR_WORD / SU_CMD_RD_WORD / SU_CMD_RD_BURST byte frames into bus transactions and returns read data as
//  SU_CMD_RSP frames. Non-command bytes pass through to the console path. Generalises the single-32-bit-word gateway to
//  parametrised address/data widths, burst reads and an inter-byte timeout.
// PARAMETERS
//  ADDR_BYTES   4      address bytes per frame (1..4); bus_addr width = 8*ADDR_BYTES
//  DATA_BYTES   4      data bytes per word (1..8); bus data width = 8*DATA_BYTES
//  TIMEOUT_CYC  50000  max clk cycles between bytes of one frame before abort (>=2)
//  WR_ACK_EN    0      1: each completed write returns a 1-byte SU_CMD_RSP frame
// PORTS
//  clk          in   1        clock
//  rst          in   1        asynchronous active-high reset
//  rx_byte      in   8        received byte, valid with rx_valid
//  rx_valid     in   1        1-cycle strobe per received byte; no backpressure
//  tx_byte      out  8        byte to UART transmitter
//  tx_valid     out  1        tx_byte valid; held until tx_ready
//  tx_ready     in   1        transmitter accepts tx_byte when tx_valid & tx_ready
//  pt_byte      out  8        pass-through (console) byte
//  pt_valid     out  1        1-cycle strobe, pt_byte valid
//  bus_req      out  1        bus request; held until bus_ack
//  bus_we       out  1        1 = write, 0 = read
//  bus_addr     out  8*AB     bus address
//  bus_wdata    out  8*DB     write data
//  bus_rdata    in   8*DB     read data, sampled on bus_ack cycle
//  bus_ack      in   1        1-cycle completion strobe
//  busy         out  1        engine not in IDLE
//  err_timeout  out  1        1-cycle pulse: frame aborted by timeout
//  err_overrun  out  1        1-cycle pulse: rx byte dropped (arrived during BUS_*/SEND_*)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. rst mid-frame/mid-bus-cycle drops it; bus_req falls immediately.
//  Byte order: multi-byte fields MS byte first; counters count down.
//  FSM: IDLE -> GET_ADDR -> (GET_DATA | GET_CNT | BUS_RD) -> BUS_WR/BUS_RD -> SEND_HDR -> SEND_DATA -> IDLE.
//   IDLE: rx byte == WR_WORD/RD_WORD/RD_BURST -> latch opcode, GET_ADDR. Any other byte -> pt_byte/pt_valid next cycle.
//   GET_ADDR: shift ADDR_BYTES bytes; then WR->GET_DATA, RD->BUS_RD (cnt=0), BURST->GET_CNT.
//   GET_DATA: shift DATA_BYTES bytes -> BUS_WR. GET_CNT: 1 byte N -> BUS_RD, N+1 reads total (N=255 -> 256).
//   BUS_WR: bus_req=1,bus_we=1 registered outputs, asserted cycle after entry; on bus_ack -> IDLE (WR_ACK_EN: SEND_HDR, no data).
//   BUS_RD: bus_req=1,bus_we=0; on ack latch rdata; first word -> SEND_HDR, later words -> SEND_DATA.
//   SEND_HDR: tx_byte=SU_CMD_RSP until accepted. SEND_DATA: DATA_BYTES bytes MS first, one per accepted handshake.
//   After last byte: cnt>0 -> cnt--, bus_addr += DATA_BYTES (wraps modulo 2^(8*ADDR_BYTES)), BUS_RD; else IDLE.
//   Burst response = one SU_CMD_RSP then (N+1)*DATA_BYTES data bytes.
//  tx_valid never drops before handshake; tx_byte stable while tx_valid & !tx_ready.
//  Timeout: counter clears on each rx_valid; only runs in GET_*; reaching TIMEOUT_CYC -> err_timeout pulse, IDLE, no bus cycle.
//  rx_valid in BUS_*/SEND_*: byte discarded, err_overrun pulses; state unaffected.
//  rx_valid on same cycle as timeout expiry: byte wins (counter clears, no abort).
//  Command byte seen while in GET_* is treated as data, not a restart.
// STRUCTURE
//  Package su_pkg: SU_CMD_WR_WORD, SU_CMD_RD_WORD, SU_CMD_RSP (same values as existing SU_CMD_* defines),
//   new SU_CMD_RD_BURST, su_state_t enum.
//  Sub-module su_shift_in: byte-serial shift register with byte counter, reused for address and data capture.
//  Timeout counter, tx serialiser and FSM in top level.
// TESTING
//  1 WR_WORD,12,34,56,78,de,ad,be,ef -> one bus write addr=0x12345678 wdata=0xdeadbeef; no tx bytes.
//  2 RD_WORD,00,00,01,00; bus_rdata=0xcafef00d -> tx: SU_CMD_RSP,ca,fe,f0,0d; tx_ready toggled 1/0 keeps bytes stable.
//  3 RD_BURST,ff,ff,ff,fc,02 -> reads 0xfffffffc,0x00000000,0x00000004 (wrap); tx = RSP + 12 data bytes.
//  4 WR_WORD,12,34 then idle TIMEOUT_CYC cycles -> err_timeout pulse, no bus_req; next 'A'(0x41) -> pt_valid, pt_byte=0x41.
//  5 rx byte during BUS_RD with bus_ack held off 20 cycles -> err_overrun pulse; response unchanged.
//  6 rst asserted mid-SEND_DATA and mid-BUS_WR -> all outputs 0 same cycle; next RD_WORD frame works normally.

Source files
------------

// File: rtl/su_pkg.sv
// ---------------------------------------------------------------------------
// su_pkg
// Shared definitions for the smart-UART command engine: frame opcodes, the
// engine state encoding and the decoded-opcode type.
// ---------------------------------------------------------------------------
package su_pkg;

    // Frame opcodes (first byte of a command frame, and the response header).
    localparam logic [7:0] SU_CMD_WR_WORD  = 8'hA1;
    localparam logic [7:0] SU_CMD_RD_WORD  = 8'hA2;
    localparam logic [7:0] SU_CMD_RSP      = 8'hA3;
    localparam logic [7:0] SU_CMD_RD_BURST = 8'hA4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_GET_CNT,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_SEND_HDR,
        ST_SEND_DATA
    } su_state_t;

    typedef enum logic [1:0] {
        OP_WR,
        OP_RD,
        OP_BURST
    } su_op_t;

    // True for the bytes that open a command frame when seen in IDLE.
    function automatic logic su_is_cmd(input logic [7:0] b);
        return (b == SU_CMD_WR_WORD) || (b == SU_CMD_RD_WORD) || (b == SU_CMD_RD_BURST);
    endfunction

    function automatic su_op_t su_decode_op(input logic [7:0] b);
        su_op_t op;
        case (b)
            SU_CMD_WR_WORD: op = OP_WR;
            SU_CMD_RD_WORD: op = OP_RD;
            default:        op = OP_BURST;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/su_shift_in.sv
// ---------------------------------------------------------------------------
// su_shift_in
// Byte-serial shift register, MS byte first, with a down-counting byte
// counter. 'last' is high while the next shifted byte completes the field;
// the counter reloads itself after that byte so the field can be reused.
// A parallel load lets the owner overwrite the value (used for burst
// address increments).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr        re-arm byte counter (field value is kept)
//   shift_en   shift byte_in into the LS byte
//   byte_in    incoming byte
//   load_en    overwrite value with load_val (wins over shift)
//   load_val   parallel load value
//   data       current field value
//   last       next shifted byte is the final byte of the field
// ---------------------------------------------------------------------------
module su_shift_in #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  shift_en,
    input  logic [7:0]            byte_in,
    input  logic                  load_en,
    input  logic [8*NBYTES-1:0]   load_val,
    output logic [8*NBYTES-1:0]   data,
    output logic                  last
);

    localparam int W = 8 * NBYTES;
    localparam logic [3:0] CNT_INIT = 4'(NBYTES - 1);

    logic [W-1:0] data_q, data_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [W+7:0] shifted;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        shifted = {data_q, byte_in};
        if (clr) begin
            cnt_d = CNT_INIT;
        end else if (shift_en) begin
            data_d = shifted[W-1:0];
            cnt_d  = (cnt_q == 4'd0) ? CNT_INIT : cnt_q - 4'd1;
        end
        if (load_en) begin
            data_d = load_val;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= CNT_INIT;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data = data_q;
    assign last = (cnt_q == 4'd0);

endmodule

// File: rtl/su_cmd_engine.sv
// ---------------------------------------------------------------------------
// su_cmd_engine
// Smart-UART command engine. Decodes WR_WORD / RD_WORD / RD_BURST frames
// received from the UART into bus transactions and returns read data as
// RSP frames. Bytes that do not open a frame are passed to the console.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rx_byte/rx_valid      received byte strobe (no backpressure)
//   tx_byte/tx_valid      byte to transmitter, held until tx_ready
//   tx_ready              transmitter accept
//   pt_byte/pt_valid      console pass-through byte strobe
//   bus_req/bus_we        bus request (held until bus_ack) and direction
//   bus_addr/bus_wdata    bus address and write data
//   bus_rdata/bus_ack     read data, sampled on the ack strobe
//   busy                  engine not idle
//   err_timeout           pulse: frame dropped after inter-byte timeout
//   err_overrun           pulse: rx byte dropped during a bus/send phase
// ---------------------------------------------------------------------------
module su_cmd_engine
    import su_pkg::*;
#(
    parameter int ADDR_BYTES  = 4,
    parameter int DATA_BYTES  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int WR_ACK_EN   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_valid,
    output logic [7:0]              tx_byte,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [7:0]              pt_byte,
    output logic                    pt_valid,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [8*ADDR_BYTES-1:0] bus_addr,
    output logic [8*DATA_BYTES-1:0] bus_wdata,
    input  logic [8*DATA_BYTES-1:0] bus_rdata,
    input  logic                    bus_ack,
    output logic                    busy,
    output logic                    err_timeout,
    output logic                    err_overrun
);

    localparam int AW    = 8 * ADDR_BYTES;
    localparam int DW    = 8 * DATA_BYTES;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       BYTE_LAST = 3'(DATA_BYTES - 1);

    su_state_t        state_q, state_d;
    su_op_t           op_q, op_d;
    logic [7:0]       cnt_q, cnt_d;          // remaining extra burst reads
    logic             first_q, first_d;      // next read is the first of the frame
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [2:0]       byte_cnt_q, byte_cnt_d; // data byte index, counts down
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_we_q, bus_we_d;
    logic             pt_valid_q, pt_valid_d;
    logic [7:0]       pt_byte_q, pt_byte_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_overrun_q, err_overrun_d;

    logic          addr_last, data_last;
    logic          addr_load;
    logic [AW-1:0] addr_inc;
    logic          in_get, in_busy_phase, tmo_expire, tx_hs;
    logic [DW-1:0] rdata_sh;

    // Address field; also holds the running burst address.
    su_shift_in #(.NBYTES(ADDR_BYTES)) u_addr (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q != ST_GET_ADDR),
        .shift_en (rx_valid && (state_q == ST_GET_ADDR)),
        .byte_in  (rx_byte),
        .load_en  (addr_load),
        .load_val (addr_inc),
        .data     (bus_addr),
        .last     (addr_last)
    );

    su_shift_in #(.NBYTES(DATA_BYTES)) u_data (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q != ST_GET_DATA),
        .shift_en (rx_valid && (state_q == ST_GET_DATA)),
        .byte_in  (rx_byte),
        .load_en  (1'b0),
        .load_val ('0),
        .data     (bus_wdata),
        .last     (data_last)
    );

    // Transmit path is decoded straight from held state, so the byte cannot
    // change while a handshake is pending.
    always_comb begin
        rdata_sh = rdata_q >> {byte_cnt_q, 3'b000};
        tx_valid = (state_q == ST_SEND_HDR) || (state_q == ST_SEND_DATA);
        tx_byte  = 8'h00;
        if (state_q == ST_SEND_HDR) begin
            tx_byte = SU_CMD_RSP;
        end else if (state_q == ST_SEND_DATA) begin
            tx_byte = rdata_sh[7:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        first_d       = first_q;
        rdata_d       = rdata_q;
        byte_cnt_d    = byte_cnt_q;
        tmo_d         = '0;
        pt_valid_d    = 1'b0;
        pt_byte_d     = pt_byte_q;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        addr_load     = 1'b0;
        addr_inc      = bus_addr + AW'(DATA_BYTES);
        tmo_expire    = 1'b0;
        tx_hs         = tx_valid && tx_ready;
        in_get        = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA) ||
                        (state_q == ST_GET_CNT);
        in_busy_phase = (state_q == ST_BUS_WR) || (state_q == ST_BUS_RD) ||
                        (state_q == ST_SEND_HDR) || (state_q == ST_SEND_DATA);

        // Inter-byte timer: a byte on the expiry cycle still clears it.
        if (in_get) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_expire = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (su_is_cmd(rx_byte)) begin
                        op_d    = su_decode_op(rx_byte);
                        state_d = ST_GET_ADDR;
                    end else begin
                        pt_valid_d = 1'b1;
                        pt_byte_d  = rx_byte;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rx_valid && addr_last) begin
                    case (op_q)
                        OP_WR:   state_d = ST_GET_DATA;
                        OP_RD: begin
                            cnt_d   = 8'd0;
                            first_d = 1'b1;
                            state_d = ST_BUS_RD;
                        end
                        default: state_d = ST_GET_CNT;
                    endcase
                end
            end
            ST_GET_DATA: begin
                if (rx_valid && data_last) begin
                    state_d = ST_BUS_WR;
                end
            end
            ST_GET_CNT: begin
                if (rx_valid) begin
                    cnt_d   = rx_byte;
                    first_d = 1'b1;
                    state_d = ST_BUS_RD;
                end
            end
            ST_BUS_WR: begin
                if (bus_ack) begin
                    state_d = (WR_ACK_EN != 0) ? ST_SEND_HDR : ST_IDLE;
                end
            end
            ST_BUS_RD: begin
                if (bus_ack) begin
                    rdata_d    = bus_rdata;
                    byte_cnt_d = BYTE_LAST;
                    first_d    = 1'b0;
                    // Only the first word of a frame carries the header.
                    state_d    = first_q ? ST_SEND_HDR : ST_SEND_DATA;
                end
            end
            ST_SEND_HDR: begin
                if (tx_hs) begin
                    state_d = (op_q == OP_WR) ? ST_IDLE : ST_SEND_DATA;
                end
            end
            ST_SEND_DATA: begin
                if (tx_hs) begin
                    if (byte_cnt_q != 3'd0) begin
                        byte_cnt_d = byte_cnt_q - 3'd1;
                    end else if (cnt_q != 8'd0) begin
                        cnt_d     = cnt_q - 8'd1;
                        addr_load = 1'b1;
                        state_d   = ST_BUS_RD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Expiry only happens in GET_* without an rx byte, so it never
        // competes with a field completing on the same cycle.
        if (tmo_expire) begin
            state_d       = ST_IDLE;
            err_timeout_d = 1'b1;
        end

        if (rx_valid && in_busy_phase) begin
            err_overrun_d = 1'b1;
        end

        // Registered bus strobes follow the state being entered.
        bus_req_d = (state_d == ST_BUS_WR) || (state_d == ST_BUS_RD);
        bus_we_d  = (state_d == ST_BUS_WR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_WR;
            cnt_q         <= 8'd0;
            first_q       <= 1'b0;
            rdata_q       <= '0;
            byte_cnt_q    <= 3'd0;
            tmo_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            pt_valid_q    <= 1'b0;
            pt_byte_q     <= 8'h00;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            first_q       <= first_d;
            rdata_q       <= rdata_d;
            byte_cnt_q    <= byte_cnt_d;
            tmo_q         <= tmo_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            pt_valid_q    <= pt_valid_d;
            pt_byte_q     <= pt_byte_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign pt_valid    = pt_valid_q;
    assign pt_byte     = pt_byte_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_su_cmd_engine.sv
// ---------------------------------------------------------------------------
// tb_su_cmd_engine
// Self-checking bench for su_cmd_engine (4-byte address/data, short timeout).
// A bus responder returns rd_fn(addr) as read data and logs every completed
// transaction; a monitor logs accepted tx bytes and pass-through bytes. The
// reference model turns each frame into the expected transaction list and
// byte stream, which are compared after the engine returns to idle.
// ---------------------------------------------------------------------------
module tb_su_cmd_engine;
    import su_pkg::*;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  pt_byte;
    logic        pt_valid;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack = 1'b0;
    logic        busy;
    logic        err_timeout;
    logic        err_overrun;

    su_cmd_engine #(
        .ADDR_BYTES (4),
        .DATA_BYTES (4),
        .TIMEOUT_CYC(TMO),
        .WR_ACK_EN  (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .pt_byte    (pt_byte),
        .pt_valid   (pt_valid),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t       bus_log[$], exp_bus[$];
    logic [7:0] tx_log[$], exp_tx[$], pt_log[$], exp_pt[$];

    int n_checks = 0;
    int n_errs   = 0;
    int n_tmo    = 0;
    int n_ovr    = 0;
    int ack_delay  = 2;
    int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
    int wait_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents seen by the engine: a fixed function of the address.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return a ^ 32'hCAFE_F10D;
    endfunction

    // ---------------- bus responder ----------------
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus_ack  = 1'b0;
            wait_cnt = 0;
        end else if (bus_ack) begin
            bus_ack  = 1'b0;
            wait_cnt = 0;
        end else if (bus_req) begin
            if (wait_cnt >= ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = rd_fn(bus_addr);
                bus_log.push_back('{we: bus_we, addr: bus_addr, wdata: bus_wdata});
            end else begin
                wait_cnt++;
            end
        end
    end

    // ---------------- transmitter ready ----------------
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- output monitor (opposite edge) ----------------
    logic       pend = 1'b0;
    logic [7:0] pend_byte = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("tx_hold_valid", 64'(tx_valid), 64'(1));
                check("tx_hold_byte", 64'(tx_byte), 64'(pend_byte));
            end
            if (tx_valid && tx_ready) tx_log.push_back(tx_byte);
            pend      = tx_valid && !tx_ready;
            pend_byte = tx_byte;
            if (pt_valid) pt_log.push_back(pt_byte);
            if (err_timeout) n_tmo++;
            if (err_overrun) n_ovr++;
        end
    end

    // ---------------- reference model ----------------
    task automatic model_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) exp_tx.push_back(w[8*k +: 8]);
    endtask

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
        exp_bus.push_back('{we: 1'b1, addr: a, wdata: d});
    endtask

    task automatic model_burst(input logic [31:0] a, input int n);
        logic [31:0] aa;
        exp_tx.push_back(SU_CMD_RSP);
        for (int i = 0; i <= n; i++) begin
            aa = a + 32'(4 * i);
            exp_bus.push_back('{we: 1'b0, addr: aa, wdata: 32'h0});
            model_word(rd_fn(aa));
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic send_wr(input logic [31:0] a, input logic [31:0] d, input int gap);
        send_byte(SU_CMD_WR_WORD, gap);
        send_word(a, gap);
        send_word(d, gap);
    endtask

    task automatic send_rd(input logic [31:0] a, input int gap);
        send_byte(SU_CMD_RD_WORD, gap);
        send_word(a, gap);
    endtask

    task automatic send_burst(input logic [31:0] a, input logic [7:0] n, input int gap);
        send_byte(SU_CMD_RD_BURST, gap);
        send_word(a, gap);
        send_byte(n, gap);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || bus_req) && n < 5000) begin
            tick();
            n++;
        end
        check("idle_reached", 64'(busy), 64'(0));
        repeat (3) tick();
    endtask

    task automatic compare_logs(input string name);
        check({name, "_bus_count"}, 64'(bus_log.size()), 64'(exp_bus.size()));
        for (int i = 0; i < bus_log.size() && i < exp_bus.size(); i++) begin
            check({name, "_bus_we"}, 64'(bus_log[i].we), 64'(exp_bus[i].we));
            check({name, "_bus_addr"}, 64'(bus_log[i].addr), 64'(exp_bus[i].addr));
            if (exp_bus[i].we) check({name, "_bus_wdata"}, 64'(bus_log[i].wdata), 64'(exp_bus[i].wdata));
        end
        check({name, "_tx_count"}, 64'(tx_log.size()), 64'(exp_tx.size()));
        for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
            check({name, "_tx_byte"}, 64'(tx_log[i]), 64'(exp_tx[i]));
        check({name, "_pt_count"}, 64'(pt_log.size()), 64'(exp_pt.size()));
        for (int i = 0; i < pt_log.size() && i < exp_pt.size(); i++)
            check({name, "_pt_byte"}, 64'(pt_log[i]), 64'(exp_pt[i]));
        bus_log.delete(); exp_bus.delete();
        tx_log.delete();  exp_tx.delete();
        pt_log.delete();  exp_pt.delete();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, 64'({tx_byte, tx_valid, pt_byte, pt_valid, bus_req, bus_we,
                                    busy, err_timeout, err_overrun}), 64'(0));
        check({name, "_addr"}, 64'(bus_addr), 64'(0));
        check({name, "_wdata"}, 64'(bus_wdata), 64'(0));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        bus_log.delete(); tx_log.delete(); pt_log.delete();
    endtask

    // ---------------- vector table: single-word frames ----------------
    typedef enum int { K_WR, K_RD, K_PT } kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] addr;   // address, or pass-through byte in [7:0]
        logic [31:0] data;   // write data
        logic [31:0] exp;    // expected wdata / rdata / pass-through byte
    } vec_t;

    vec_t vecs[7];

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        logic [31:0] a, d;
        logic [7:0]  b;
        int n, kind, gap;

        vecs[0] = '{K_WR, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{K_RD, 32'h0000_0100, 32'h0,         32'hCAFE_F00D};
        vecs[2] = '{K_RD, 32'h0000_0000, 32'h0,         32'hCAFE_F10D};
        vecs[3] = '{K_RD, 32'hFFFF_FFFF, 32'h0,         32'h3501_0EF2};
        vecs[4] = '{K_WR, 32'h0000_0004, 32'h0000_0001, 32'h0000_0001};
        vecs[5] = '{K_PT, 32'h0000_0041, 32'h0,         32'h0000_0041};
        vecs[6] = '{K_PT, 32'h0000_00A3, 32'h0,         32'h0000_00A3};

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) tick();
        check_all_zero("reset_state");
        rst = 1'b0;
        tick();

        // Table-driven single-word frames, toggling tx_ready.
        ready_mode = 1;
        for (int i = 0; i < 7; i++) begin
            case (vecs[i].kind)
                K_WR: begin
                    send_wr(vecs[i].addr, vecs[i].data, 0);
                    exp_bus.push_back('{we: 1'b1, addr: vecs[i].addr, wdata: vecs[i].exp});
                end
                K_RD: begin
                    send_rd(vecs[i].addr, 0);
                    exp_bus.push_back('{we: 1'b0, addr: vecs[i].addr, wdata: 32'h0});
                    exp_tx.push_back(SU_CMD_RSP);
                    model_word(vecs[i].exp);
                end
                default: begin
                    send_byte(vecs[i].addr[7:0], 0);
                    exp_pt.push_back(vecs[i].exp[7:0]);
                end
            endcase
            wait_idle();
            compare_logs($sformatf("vec%0d", i));
        end

        // Burst with address wrap: fffffffc, 00000000, 00000004.
        ready_mode = 2;
        send_burst(32'hFFFF_FFFC, 8'd2, 0);
        exp_tx.push_back(SU_CMD_RSP);
        exp_bus.push_back('{we: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0});
        model_word(32'h3501_0EF1);
        exp_bus.push_back('{we: 1'b0, addr: 32'h0000_0000, wdata: 32'h0});
        model_word(32'hCAFE_F10D);
        exp_bus.push_back('{we: 1'b0, addr: 32'h0000_0004, wdata: 32'h0});
        model_word(32'hCAFE_F109);
        wait_idle();
        compare_logs("burst_wrap");

        // Command opcodes inside the address/data fields are plain data.
        ready_mode = 0;
        send_wr({SU_CMD_RD_WORD, SU_CMD_RSP, SU_CMD_WR_WORD, SU_CMD_RD_BURST},
                {4{SU_CMD_WR_WORD}}, 0);
        model_wr({SU_CMD_RD_WORD, SU_CMD_RSP, SU_CMD_WR_WORD, SU_CMD_RD_BURST}, {4{SU_CMD_WR_WORD}});
        wait_idle();
        compare_logs("cmd_as_data");

        // Longest legal inter-byte gap: a byte on the expiry cycle wins.
        send_wr(32'h0BAD_F00D, 32'h0000_5555, TMO - 1);
        model_wr(32'h0BAD_F00D, 32'h0000_5555);
        wait_idle();
        compare_logs("gap_max");
        check("gap_max_no_timeout", 64'(n_tmo), 64'(0));

        // Timeout one cycle later aborts the frame without a bus cycle.
        send_byte(SU_CMD_WR_WORD, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, TMO - 1);
        check("tmo_not_yet", 64'(err_timeout), 64'(0));
        check("tmo_busy_before", 64'(busy), 64'(1));
        tick();
        check("tmo_pulse", 64'(err_timeout), 64'(1));
        check("tmo_idle", 64'(busy), 64'(0));
        check("tmo_no_req", 64'(bus_req), 64'(0));
        tick();
        check("tmo_pulse_end", 64'(err_timeout), 64'(0));
        send_byte(8'h41, 0);
        exp_pt.push_back(8'h41);
        wait_idle();
        compare_logs("tmo_then_pt");
        check("tmo_count", 64'(n_tmo), 64'(1));

        // Overrun: byte during a stalled bus read is dropped.
        ack_delay = 20;
        send_rd(32'h0000_0200, 0);
        repeat (3) tick();
        check("ovr_in_bus", 64'(bus_req), 64'(1));
        send_byte(8'h55, 0);
        tick();
        model_burst(32'h0000_0200, 0);
        wait_idle();
        compare_logs("overrun");
        check("ovr_count", 64'(n_ovr), 64'(1));

        // Reset during SEND_DATA.
        ack_delay  = 2;
        ready_mode = 1;
        send_rd(32'h0000_0300, 0);
        t0 = 0;
        while (tx_log.size() < 2 && t0 < 200) begin
            tick();
            t0++;
        end
        check("rst_send_reached", 64'(tx_log.size() >= 2), 64'(1));
        check("rst_send_busy", 64'(busy), 64'(1));
        pulse_reset();
        check_all_zero("after_rst_send");

        // Reset during BUS_WR.
        ack_delay = 20;
        send_wr(32'h0000_0400, 32'h1111_2222, 0);
        repeat (3) tick();
        check("rst_buswr_req", 64'(bus_req), 64'(1));
        check("rst_buswr_we", 64'(bus_we), 64'(1));
        pulse_reset();
        ack_delay = 2;
        send_rd(32'h0000_0100, 0);
        model_burst(32'h0000_0100, 0);
        wait_idle();
        compare_logs("after_rst_rd");

        // Maximum burst length: N=255 gives 256 reads, wrapping mid-burst.
        ready_mode = 0;
        ack_delay  = 0;
        send_burst(32'hFFFF_FF00, 8'd255, 0);
        model_burst(32'hFFFF_FF00, 255);
        wait_idle();
        compare_logs("burst_256");

        // Randomized frames against the model.
        for (int it = 0; it < 30; it++) begin
            kind       = $urandom_range(0, 3);
            gap        = $urandom_range(0, 3);
            ack_delay  = $urandom_range(0, 4);
            ready_mode = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            d = $urandom;
            case (kind)
                0: begin
                    send_wr(a, d, gap);
                    model_wr(a, d);
                end
                1: begin
                    send_rd(a, gap);
                    model_burst(a, 0);
                end
                2: begin
                    n = $urandom_range(0, 4);
                    send_burst(a, 8'(n), gap);
                    model_burst(a, n);
                end
                default: begin
                    do b = 8'($urandom);
                    while (b == SU_CMD_WR_WORD || b == SU_CMD_RD_WORD || b == SU_CMD_RD_BURST);
                    send_byte(b, gap);
                    exp_pt.push_back(b);
                end
            endcase
            wait_idle();
            compare_logs($sformatf("rand%0d", it));
        end
        check("final_tmo_count", 64'(n_tmo), 64'(1));
        check("final_ovr_count", 64'(n_ovr), 64'(1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
